// File: rtl/stream_watchdog.sv
// stream_watchdog: protocol checker for a valid/ready stream.
// It detects stability, timeout and abandon violations on a monitored stream.
// Each violation is timestamped and queued as an event record in a small FIFO.
// Optional feature: define STREAM_WATCHDOG_XFER_EN to also log every completed
// transfer as an INFO/XFER record. This record has the lowest priority.
module stream_watchdog #(
    parameter int DATA_WIDTH = 8,
    parameter int TS_WIDTH   = 32,
    parameter int TIMEOUT    = 16,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mon_valid,
    input  logic                  mon_ready,
    input  logic [DATA_WIDTH-1:0] mon_data,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [2:0]            evt_level,
    output logic [1:0]            evt_code,
    output logic [TS_WIDTH-1:0]   evt_time,
    output logic [DATA_WIDTH-1:0] evt_data,
    output logic [7:0]            dropped
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] LVL_WARN  = 3'd3;
    localparam logic [2:0] LVL_ERROR = 3'd4;
    localparam logic [1:0] CODE_STAB = 2'd1;
    localparam logic [1:0] CODE_ABND = 2'd2;
    localparam logic [1:0] CODE_TOUT = 2'd3;
`ifdef STREAM_WATCHDOG_XFER_EN
    localparam logic [2:0] LVL_INFO  = 3'd2;
    localparam logic [1:0] CODE_XFER = 2'd0;
`endif

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    typedef struct packed {
        logic [2:0]            level;
        logic [1:0]            code;
        logic [TS_WIDTH-1:0]   time_s;
        logic [DATA_WIDTH-1:0] data;
    } rec_t;

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] held_reg, held_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic                  stab_rep_reg, stab_rep_next;
    logic                  to_rep_reg, to_rep_next;     // timeout already detected in this stall
    logic                  to_pend_reg, to_pend_next;   // detected timeout waiting for a push slot
    logic [TS_WIDTH-1:0]   to_time_reg, to_time_next;
    logic [TS_WIDTH-1:0]   ts_reg;

    logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]        count_reg;
    logic [7:0]            dropped_reg;
    rec_t                  mem [DEPTH];

    logic stalled, xfer, stab_hit, to_hit, full, wr_en, pop, push;
    logic [CNT_W-1:0] cnt_inc;
    rec_t push_rec, rd_rec;

    assign stalled  = mon_valid & ~mon_ready;
    assign xfer     = mon_valid & mon_ready;
    assign cnt_inc  = (cnt_reg == CNT_W'(TIMEOUT)) ? cnt_reg : cnt_reg + CNT_W'(1);
    assign stab_hit = mon_valid && (mon_data != held_reg) && !stab_rep_reg;
    assign to_hit   = stalled && (cnt_reg == CNT_W'(TIMEOUT - 1)) && !to_rep_reg;

    // Free-running timestamp, restarted by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) ts_reg <= '0;
        else        ts_reg <= ts_reg + TS_WIDTH'(1);
    end

    // Stall tracker state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            held_reg     <= '0;
            cnt_reg      <= '0;
            stab_rep_reg <= 1'b0;
            to_rep_reg   <= 1'b0;
            to_pend_reg  <= 1'b0;
            to_time_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            held_reg     <= held_next;
            cnt_reg      <= cnt_next;
            stab_rep_reg <= stab_rep_next;
            to_rep_reg   <= to_rep_next;
            to_pend_reg  <= to_pend_next;
            to_time_reg  <= to_time_next;
        end
    end

    // Next-state and prioritised event selection (one push per cycle).
    always_comb begin
        state_next      = state_reg;
        held_next       = held_reg;
        cnt_next        = cnt_reg;
        stab_rep_next   = stab_rep_reg;
        to_rep_next     = to_rep_reg;
        to_pend_next    = to_pend_reg;
        to_time_next    = to_time_reg;
        push            = 1'b0;
        push_rec        = '0;
        push_rec.time_s = ts_reg;
        case (state_reg)
            ST_IDLE: begin
                if (stalled) begin
                    state_next    = ST_WAIT;
                    held_next     = mon_data;
                    cnt_next      = CNT_W'(1);
                    stab_rep_next = 1'b0;
                    to_rep_next   = 1'b0;
                    to_pend_next  = 1'b0;
                    // With a one-cycle timeout the first stalled cycle already expires.
                    if (TIMEOUT == 1) begin
                        push          = 1'b1;
                        push_rec.level = LVL_ERROR;
                        push_rec.code  = CODE_TOUT;
                        push_rec.data  = mon_data;
                        to_rep_next   = 1'b1;
                    end
                end
`ifdef STREAM_WATCHDOG_XFER_EN
                else if (xfer) begin
                    push           = 1'b1;
                    push_rec.level = LVL_INFO;
                    push_rec.code  = CODE_XFER;
                    push_rec.data  = mon_data;
                end
`endif
            end
            ST_WAIT: begin
                if (stalled) cnt_next = cnt_inc;
                if (stab_hit) begin
                    push           = 1'b1;
                    push_rec.level = LVL_ERROR;
                    push_rec.code  = CODE_STAB;
                    push_rec.data  = mon_data;
                    stab_rep_next  = 1'b1;
                    // A simultaneous timeout is deferred but keeps this cycle's time.
                    if (to_hit) begin
                        to_rep_next  = 1'b1;
                        to_pend_next = 1'b1;
                        to_time_next = ts_reg;
                    end
                end else if (to_pend_reg) begin
                    push            = 1'b1;
                    push_rec.level  = LVL_ERROR;
                    push_rec.code   = CODE_TOUT;
                    push_rec.time_s = to_time_reg;
                    push_rec.data   = held_reg;
                    to_pend_next    = 1'b0;
                end else if (to_hit) begin
                    push           = 1'b1;
                    push_rec.level = LVL_ERROR;
                    push_rec.code  = CODE_TOUT;
                    push_rec.data  = held_reg;
                    to_rep_next    = 1'b1;
                end else if (!mon_valid) begin
                    push           = 1'b1;
                    push_rec.level = LVL_WARN;
                    push_rec.code  = CODE_ABND;
                    push_rec.data  = held_reg;
                end
`ifdef STREAM_WATCHDOG_XFER_EN
                else if (xfer) begin
                    push           = 1'b1;
                    push_rec.level = LVL_INFO;
                    push_rec.code  = CODE_XFER;
                    push_rec.data  = mon_data;
                end
`endif
                if (!mon_valid || xfer) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign full  = (count_reg == (PTR_W + 1)'(DEPTH));
    assign wr_en = push & ~full;
    assign pop   = evt_valid & evt_ready;

    // FIFO pointers, occupancy and saturating drop counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            dropped_reg <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)   rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({wr_en, pop})
                2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
                default: count_reg <= count_reg;
            endcase
            if (push && full && dropped_reg != 8'hFF) dropped_reg <= dropped_reg + 8'd1;
        end
    end

    // Record storage; no reset needed since empty entries are masked on read.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_reg] <= push_rec;
    end

    assign evt_valid = (count_reg != '0);
    assign rd_rec    = evt_valid ? mem[rd_ptr_reg] : '0;
    assign evt_level = rd_rec.level;
    assign evt_code  = rd_rec.code;
    assign evt_time  = rd_rec.time_s;
    assign evt_data  = rd_rec.data;
    assign dropped   = dropped_reg;
endmodule

// File: tb/tb_stream_watchdog.sv
// tb_stream_watchdog: directed scenarios for stream_watchdog with a queue-based
// reference model checked every cycle, plus literal checks on logged records.
module tb_stream_watchdog;
    localparam int DW = 8;
    localparam int TW = 32;
    localparam int TO = 16;
    localparam int DP = 4;
`ifdef STREAM_WATCHDOG_XFER_EN
    localparam bit XFER_EN = 1'b1;
`else
    localparam bit XFER_EN = 1'b0;
`endif

    typedef struct packed {
        logic [2:0]  lvl;
        logic [1:0]  code;
        logic [31:0] t;
        logic [7:0]  d;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mon_valid, mon_ready, evt_ready;
    logic [DW-1:0] mon_data;
    logic          evt_valid;
    logic [2:0]    evt_level;
    logic [1:0]    evt_code;
    logic [TW-1:0] evt_time;
    logic [DW-1:0] evt_data;
    logic [7:0]    dropped;

    int errors = 0;
    int checks = 0;

    rec_t mq[$];    // expected FIFO content
    rec_t got[$];   // records accepted from the DUT

    bit          model_ok = 1'b0;
    logic [31:0] m_ts;
    bit          in_stall, stab_seen, pend, m_full, m_stalled, to_new, have;
    logic [7:0]  held, held_now;
    logic [31:0] pend_t;
    int          len, len_now, m_drop;
    rec_t        ev, exp_r;
    bit          exp_v;

    stream_watchdog #(.DATA_WIDTH(DW), .TS_WIDTH(TW), .TIMEOUT(TO), .DEPTH(DP)) dut (
        .clk(clk), .rst_n(rst_n),
        .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_data(mon_data),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_level(evt_level), .evt_code(evt_code), .evt_time(evt_time), .evt_data(evt_data),
        .dropped(dropped)
    );

    always #5 clk = ~clk;

    function automatic rec_t mk(input logic [1:0] code, input logic [31:0] t, input logic [7:0] d);
        rec_t r;
        r.code = code;
        r.t    = t;
        r.d    = d;
        case (code)
            2'd0:    r.lvl = 3'd2;   // XFER -> INFO
            2'd2:    r.lvl = 3'd3;   // ABANDON -> WARN
            default: r.lvl = 3'd4;   // STABILITY, TIMEOUT -> ERROR
        endcase
        return r;
    endfunction

    // Reference model: stall length as an unbounded count, events ranked by priority.
    task model_step();
        if (!rst_n) begin
            mq.delete();
            m_drop = 0; m_ts = 0; in_stall = 0; pend = 0; stab_seen = 0; len = 0;
            model_ok = 1'b1;
        end else begin
            m_full = (mq.size() == DP);
            if (evt_ready && mq.size() > 0) mq.delete(0);
            m_stalled = mon_valid && !mon_ready;
            len_now   = in_stall ? (m_stalled ? len + 1 : len) : (m_stalled ? 1 : 0);
            held_now  = in_stall ? held : mon_data;
            to_new    = m_stalled && (len_now == TO);
            have      = 1'b1;
            ev        = '0;
            if (in_stall && mon_valid && mon_data != held && !stab_seen) begin
                ev = mk(2'd1, m_ts, mon_data);
                stab_seen = 1'b1;
                if (to_new) begin pend = 1'b1; pend_t = m_ts; end
            end else if (in_stall && pend) begin
                ev = mk(2'd3, pend_t, held);
                pend = 1'b0;
            end else if (to_new) begin
                ev = mk(2'd3, m_ts, held_now);
            end else if (in_stall && !mon_valid) begin
                ev = mk(2'd2, m_ts, held);
            end else if (XFER_EN && mon_valid && mon_ready) begin
                ev = mk(2'd0, m_ts, mon_data);
            end else begin
                have = 1'b0;
            end
            if (have) begin
                if (m_full) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    mq.push_back(ev);
                end
            end
            if (in_stall) begin
                if (!mon_valid || mon_ready) in_stall = 1'b0;
                else len = len_now;
            end else if (m_stalled) begin
                in_stall = 1'b1; held = mon_data; len = 1; stab_seen = 0; pend = 0;
            end
            m_ts++;
        end
    endtask

    // Per-cycle compare against the model, record logging, then model advance.
    always @(negedge clk) begin
        if (model_ok) begin
            exp_v = (mq.size() > 0);
            exp_r = exp_v ? mq[0] : '0;
            checks++;
            if ({evt_valid, evt_level, evt_code, evt_time, evt_data} !== {exp_v, exp_r}) begin
                errors++;
                $display("FAIL evt_out ts=%0d: got v=%0b lvl=%0d code=%0d t=%0d d=%02h, want v=%0b lvl=%0d code=%0d t=%0d d=%02h",
                         m_ts, evt_valid, evt_level, evt_code, evt_time, evt_data,
                         exp_v, exp_r.lvl, exp_r.code, exp_r.t, exp_r.d);
            end
            checks++;
            if (dropped !== 8'(m_drop)) begin
                errors++;
                $display("FAIL dropped ts=%0d: got %0d want %0d", m_ts, dropped, m_drop);
            end
        end
        if (rst_n && evt_valid === 1'b1 && evt_ready) begin
            got.push_back(mk(evt_code, evt_time, evt_data));
            got[got.size() - 1].lvl = evt_level;
            $display("event: lvl=%0d code=%0d time=%0d data=%02h", evt_level, evt_code, evt_time, evt_data);
        end
        model_step();
    end

    task automatic step(input bit v, input bit r, input logic [7:0] d, input bit er);
        mon_valid = v; mon_ready = r; mon_data = d; evt_ready = er;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit er);
        repeat (n) step(1'b0, 1'b0, 8'h00, er);
    endtask

    task automatic do_reset();
        mon_valid = 0; mon_ready = 0; mon_data = 0; rst_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        got.delete();
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic check_rec(input string name, input int idx, input logic [1:0] code,
                             input logic [31:0] t, input logic [7:0] d);
        rec_t w;
        w = mk(code, t, d);
        checks++;
        if (idx >= got.size()) begin
            errors++;
            $display("FAIL %s: record %0d missing, want lvl=%0d code=%0d t=%0d d=%02h",
                     name, idx, w.lvl, w.code, w.t, w.d);
        end else if (got[idx] !== w) begin
            errors++;
            $display("FAIL %s: got lvl=%0d code=%0d t=%0d d=%02h want lvl=%0d code=%0d t=%0d d=%02h",
                     name, got[idx].lvl, got[idx].code, got[idx].t, got[idx].d, w.lvl, w.code, w.t, w.d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        mon_valid = 0; mon_ready = 0; mon_data = 0; evt_ready = 1; rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        check("reset_valid", evt_valid, 1'b0);
        check("reset_fields", {evt_level, evt_code, evt_time, evt_data}, '0);
        check("reset_dropped", dropped, 8'd0);

        // Clean stall then accept: only an XFER record when enabled.
        do_reset();
        repeat (3) step(1, 0, 8'hA5, 1);
        step(1, 1, 8'hA5, 1);
        idle(4, 1);
`ifdef STREAM_WATCHDOG_XFER_EN
        check("s1_count", got.size(), 1);
        check_rec("s1_xfer", 0, 2'd0, 32'd3, 8'hA5);
`else
        check("s1_count", got.size(), 0);
`endif

        // Data changes twice in one stall: single STABILITY at the first change.
        do_reset();
        idle(3, 1);
        step(1, 0, 8'h11, 1);
        step(1, 0, 8'h11, 1);
        step(1, 0, 8'h22, 1);
        step(1, 0, 8'h33, 1);
        step(1, 1, 8'h33, 1);
        idle(4, 1);
        check_rec("s2_stab", 0, 2'd1, 32'd5, 8'h22);
`ifdef STREAM_WATCHDOG_XFER_EN
        check("s2_count", got.size(), 2);
        check_rec("s2_xfer", 1, 2'd0, 32'd7, 8'h33);
`else
        check("s2_count", got.size(), 1);
`endif

        // 20-cycle stall from ts=10: one TIMEOUT at ts=25.
        do_reset();
        idle(10, 1);
        repeat (20) step(1, 0, 8'h3C, 1);
        step(1, 1, 8'h3C, 1);
        idle(4, 1);
        check_rec("s3_timeout", 0, 2'd3, 32'd25, 8'h3C);
`ifdef STREAM_WATCHDOG_XFER_EN
        check("s3_count", got.size(), 2);
`else
        check("s3_count", got.size(), 1);
`endif

        // Data change on the 16th stalled cycle: STABILITY first, deferred TIMEOUT keeps ts=25.
        do_reset();
        idle(10, 1);
        repeat (15) step(1, 0, 8'h3C, 1);
        repeat (3) step(1, 0, 8'h4D, 1);
        step(1, 1, 8'h4D, 1);
        idle(4, 1);
        check_rec("s4_stab", 0, 2'd1, 32'd25, 8'h4D);
        check_rec("s4_timeout", 1, 2'd3, 32'd25, 8'h3C);
`ifdef STREAM_WATCHDOG_XFER_EN
        check_rec("s4_xfer", 2, 2'd0, 32'd28, 8'h4D);
`else
        check("s4_count", got.size(), 2);
`endif

        // Valid withdrawn during a stall: ABANDON with the held data.
        do_reset();
        idle(2, 1);
        step(1, 0, 8'h5C, 1);
        step(1, 0, 8'h5C, 1);
        step(0, 0, 8'h00, 1);
        idle(4, 1);
        check("s5_count", got.size(), 1);
        check_rec("s5_abandon", 0, 2'd2, 32'd4, 8'h5C);

        // Six violations into a 4-deep FIFO, then a push while full coinciding with a pop.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 8'(8'h60 + i), 0);
            step(0, 0, 8'h00, 0);
        end
        check("s6_full_valid", evt_valid, 1'b1);
        check("s6_dropped2", dropped, 8'd2);
        step(1, 0, 8'h70, 0);
        step(0, 0, 8'h00, 1);
        check("s6_dropped3", dropped, 8'd3);
        idle(4, 1);
        check("s6_empty", evt_valid, 1'b0);
        check("s6_count", got.size(), 4);
        for (int i = 0; i < 4; i++)
            check_rec("s6_order", i, 2'd2, 32'(2 * i + 1), 8'(8'h60 + i));

        // Reset mid-stall with two queued entries.
        do_reset();
        step(1, 0, 8'h90, 0);
        step(0, 0, 8'h00, 0);
        step(1, 0, 8'h91, 0);
        step(0, 0, 8'h00, 0);
        step(1, 0, 8'h77, 0);
        step(1, 0, 8'h77, 0);
        check("s7_queued", evt_valid, 1'b1);
        do_reset();
        check("s7_valid", evt_valid, 1'b0);
        check("s7_dropped", dropped, 8'd0);
        step(1, 0, 8'h88, 1);
        step(0, 0, 8'h00, 1);
        idle(4, 1);
        check("s7_count", got.size(), 1);
        check_rec("s7_ts_restart", 0, 2'd2, 32'd1, 8'h88);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
